fc_sc_layer: RTL and testbench
==============================

# fc_sc_layer

Parametrised fully connected stochastic-computing layer: N_IN input bitstreams drive N_OUT neurons, each with a signed weighted sum and an FSM-based saturating-counter (Btanh) activation. It emits per-cycle activation bits `z`, derivative-gate bits `zp`, and windowed firing-rate counts for monitoring and training. It is the generic successor of the fixed-size fully connected layer blocks and sits between stochastic number generators (upstream) and the next layer or the output comparator.

## Interface
- N_IN, 25: inputs per neuron
- N_OUT, 8: neurons in the layer
- STATE_W, 8: activation counter width; HALF = 2^(STATE_W-1)
- BAND, 4: half-width of the derivative band around HALF, 1 ≤ BAND ≤ HALF
- WIN_LOG2, 8: rate window is 2^WIN_LOG2 enabled cycles

- CLK  in  1  clock, rising edge
- INIT_N  in  1  asynchronous active-low reset
- en  in  1  advance enable; low freezes all state
- restart  in  1  synchronous re-initialisation (training-epoch boundary)
- a  in  N_IN  input bitstreams
- w  in  N_OUT*N_IN  weight magnitude bitstreams; neuron j uses w[j*N_IN +: N_IN]
- w_sign  in  N_OUT*N_IN  weight signs, quasi-static, 1 = negative
- b, b_sign  in  N_OUT each  bias bitstream and static sign
- state_init  in  N_OUT  restart value select: 1 → HALF, 0 → HALF-1
- z  out  N_OUT  activation bit
- zp  out  N_OUT  derivative gate
- rate  out  N_OUT*(WIN_LOG2+1)  ones count of z over the last window
- rate_valid  out  1  one-cycle pulse when rate updates

## Operation
- Per neuron j, per cycle: p_i = a[i] & w[j,i]; delta = Σ(p_i & ~sign) − Σ(p_i & sign) + (b[j] ? (b_sign[j] ? −1 : +1) : 0); range ±(N_IN+1), signed width clog2(N_IN+2)+1.
- Enabled edge: S_j ← clamp(S_j + delta, 0, 2^STATE_W − 1). Compute in STATE_W+2 bits before clamping; no wrap-around.
- z[j] = S_j ≥ HALF (the MSB of S_j). zp[j] = HALF−BAND ≤ S_j ≤ HALF+BAND−1. Both are combinational from the register S_j.
- Rate monitor: cnt counts enabled edges and ones_j accumulates the current z[j] on each enabled edge. On the edge where cnt = 2^WIN_LOG2−1: rate_j ← ones_j + z[j], ones_j ← 0, cnt ← 0, rate_valid ← 1. rate_valid is 0 on every other edge.
- restart (enabled or not): S_j ← state_init[j] ? HALF : HALF−1; cnt ← 0; ones ← 0; rate_valid ← 0; rate is held. restart has priority over en and over the window-end event.
- en low, restart low: S, cnt, ones and rate hold; rate_valid ← 0.

## Timing
- Reset values: S_j = HALF−1, so z = 0 and zp = 1. rate = 0, rate_valid = 0, cnt = 0, ones = 0.
- Latency: inputs sampled at edge t appear in z/zp after edge t, i.e. one register.
- rate_valid is high for exactly one cycle, the cycle after the closing edge; rate is stable until the next window closes.
- Reset asserted mid-window discards the partial window immediately, without waiting for the clock.
- w_sign, b_sign and state_init change only while en = 0 or restart = 1.

## Structure
- Package fc_sc_pkg holds the sat_add function, delta-width and HALF computation functions, and the restart-select encoding constants.
- Sub-module sc_btanh_node implements one neuron: product, signed popcount, saturating counter, z/zp decode and ones counter. It is instantiated N_OUT times in a generate loop.
- The window counter cnt and rate_valid are shared at top level and broadcast to the nodes.

## Test plan
Setup for all scenarios: N_IN=4, N_OUT=2, STATE_W=4 (HALF=8), BAND=2, WIN_LOG2=3.
- Reset release with en=0 → S=7, z=00, zp=11, rate=0, rate_valid=0; values hold while en=0.
- a=1111, w all 1, signs 0, b=0, en=1 → S sequence 7→11→15→15 (saturates); z=1 and zp=0 from the first edge.
- Signs all 1, b=1, b_sign=1 → delta=−5; S sequence 7→2→0→0; z=0; zp=1 only at S=7.
- restart with state_init=11, then all-positive stimulus for 8 enabled edges → rate_valid pulses once after the 8th edge with rate=8 per neuron; no pulse after the 7th or 9th edge.
- restart asserted together with en on the window-closing edge → S=HALF or HALF−1 per state_init, cnt=0, no rate_valid pulse, previous rate held.
- en toggled 1,0,0,1 during a window → S and cnt frozen on the disabled edges; the window closes after 8 enabled edges (10 clocks total).

Source files
------------

// File: rtl/fc_sc_pkg.sv
// Shared helpers for the stochastic-computing fully connected layer:
// width/threshold arithmetic, saturating add and restart-select encoding.
package fc_sc_pkg;

    localparam logic INIT_SEL_HALF    = 1'b1;
    localparam logic INIT_SEL_HALF_M1 = 1'b0;

    // Signed width that holds any delta in the range -(n_in+1) .. +(n_in+1).
    function automatic int delta_width(input int n_in);
        return $clog2(n_in + 2) + 1;
    endfunction

    function automatic int half_of(input int state_w);
        return 1 << (state_w - 1);
    endfunction

    // Wide enough that s + d never wraps before the clamp.
    function automatic int sat_add(input int s, input int d, input int max_v);
        int t;
        t = s + d;
        if (t < 0)
            return 0;
        else if (t > max_v)
            return max_v;
        return t;
    endfunction

endpackage

// File: rtl/fc_sc_layer_node.sv
// One Btanh neuron: gated products, signed popcount, saturating state counter,
// z/zp decode and the per-window ones accumulator feeding the rate register.
module sc_btanh_node
    import fc_sc_pkg::*;
#(
    parameter int N_IN     = 25,
    parameter int STATE_W  = 8,
    parameter int BAND     = 4,
    parameter int WIN_LOG2 = 8
) (
    input  logic                CLK,
    input  logic                INIT_N,
    input  logic                en,
    input  logic                restart,
    input  logic                win_end,
    input  logic [N_IN-1:0]     a,
    input  logic [N_IN-1:0]     w,
    input  logic [N_IN-1:0]     w_sign,
    input  logic                b,
    input  logic                b_sign,
    input  logic                state_init,
    output logic                z,
    output logic                zp,
    output logic [WIN_LOG2:0]   rate
);

    localparam int DW    = delta_width(N_IN);
    localparam int HALF  = half_of(STATE_W);
    localparam int S_MAX = (1 << STATE_W) - 1;
    localparam int RW    = WIN_LOG2 + 1;

    localparam logic signed [DW-1:0] ONE       = DW'(1);
    localparam logic [STATE_W-1:0]   S_HALF    = STATE_W'(HALF);
    localparam logic [STATE_W-1:0]   S_HALF_M1 = STATE_W'(HALF - 1);
    localparam logic [STATE_W-1:0]   ZP_LO     = STATE_W'(HALF - BAND);
    localparam logic [STATE_W-1:0]   ZP_HI     = STATE_W'(HALF + BAND - 1);

    logic signed [DW-1:0] delta;
    logic [STATE_W-1:0]   s_d, s_q;
    logic [RW-1:0]        ones_d, ones_q;
    logic [RW-1:0]        rate_d, rate_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        delta = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (a[i] && w[i])
                delta = w_sign[i] ? delta - ONE : delta + ONE;
        end
        if (b)
            delta = b_sign ? delta - ONE : delta + ONE;
    end

    always_comb begin
        s_d    = s_q;
        ones_d = ones_q;
        rate_d = rate_q;
        if (restart) begin
            s_d    = (state_init == INIT_SEL_HALF) ? S_HALF : S_HALF_M1;
            ones_d = '0;
        end else if (en) begin
            s_d = STATE_W'(sat_add(int'(s_q), int'(delta), S_MAX));
            if (win_end) begin
                rate_d = ones_q + RW'(z);
                ones_d = '0;
            end else begin
                ones_d = ones_q + RW'(z);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            s_q    <= S_HALF_M1;
            ones_q <= '0;
            rate_q <= '0;
        end else begin
            s_q    <= s_d;
            ones_q <= ones_d;
            rate_q <= rate_d;
        end
    end

    assign z    = s_q[STATE_W-1];
    assign zp   = (s_q >= ZP_LO) && (s_q <= ZP_HI);
    assign rate = rate_q;

endmodule

// File: rtl/fc_sc_layer.sv
// Fully connected stochastic-computing layer: N_OUT Btanh neurons sharing one
// rate-window counter and a rate_valid pulse.
module fc_sc_layer
    import fc_sc_pkg::*;
#(
    parameter int N_IN     = 25,
    parameter int N_OUT    = 8,
    parameter int STATE_W  = 8,
    parameter int BAND     = 4,
    parameter int WIN_LOG2 = 8
) (
    input  logic                           CLK,
    input  logic                           INIT_N,
    input  logic                           en,
    input  logic                           restart,
    input  logic [N_IN-1:0]                a,
    input  logic [N_OUT*N_IN-1:0]          w,
    input  logic [N_OUT*N_IN-1:0]          w_sign,
    input  logic [N_OUT-1:0]               b,
    input  logic [N_OUT-1:0]               b_sign,
    input  logic [N_OUT-1:0]               state_init,
    output logic [N_OUT-1:0]               z,
    output logic [N_OUT-1:0]               zp,
    output logic [N_OUT*(WIN_LOG2+1)-1:0]  rate,
    output logic                           rate_valid
);

    localparam int RW = WIN_LOG2 + 1;

    logic [WIN_LOG2-1:0] cnt_d, cnt_q;
    logic                rate_valid_d, rate_valid_q;
    logic                win_end;

    assign win_end = en && !restart && (cnt_q == '1);

    always_comb begin
        cnt_d        = cnt_q;
        rate_valid_d = win_end;
        if (restart)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + WIN_LOG2'(1);  // wraps to 0 on the closing edge
    end

    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            cnt_q        <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign rate_valid = rate_valid_q;

    for (genvar j = 0; j < N_OUT; j++) begin : g_node
        sc_btanh_node #(
            .N_IN     (N_IN),
            .STATE_W  (STATE_W),
            .BAND     (BAND),
            .WIN_LOG2 (WIN_LOG2)
        ) u_node (
            .CLK        (CLK),
            .INIT_N     (INIT_N),
            .en         (en),
            .restart    (restart),
            .win_end    (win_end),
            .a          (a),
            .w          (w[j*N_IN +: N_IN]),
            .w_sign     (w_sign[j*N_IN +: N_IN]),
            .b          (b[j]),
            .b_sign     (b_sign[j]),
            .state_init (state_init[j]),
            .z          (z[j]),
            .zp         (zp[j]),
            .rate       (rate[j*RW +: RW])
        );
    end

endmodule

// File: tb/tb_fc_sc_layer.sv
// Directed bench for fc_sc_layer with N_IN=4, N_OUT=2, STATE_W=4 (HALF=8),
// BAND=2 (zp band 6..9), WIN_LOG2=3 (8-edge window).
module tb_fc_sc_layer;

    localparam int N_IN = 4, N_OUT = 2, STATE_W = 4, BAND = 2, WIN_LOG2 = 3;

    logic       CLK = 1'b0;
    logic       INIT_N;
    logic       en, restart;
    logic [3:0] a;
    logic [7:0] w, w_sign;
    logic [1:0] b, b_sign, state_init;
    logic [1:0] z, zp;
    logic [7:0] rate;
    logic       rate_valid;

    int n_chk = 0;
    int n_bad = 0;

    fc_sc_layer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .STATE_W(STATE_W), .BAND(BAND), .WIN_LOG2(WIN_LOG2)
    ) dut (
        .CLK(CLK), .INIT_N(INIT_N), .en(en), .restart(restart), .a(a), .w(w),
        .w_sign(w_sign), .b(b), .b_sign(b_sign), .state_init(state_init),
        .z(z), .zp(zp), .rate(rate), .rate_valid(rate_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       en, rs;
        logic [3:0] a;
        logic [7:0] w, ws;
        logic [1:0] b, bs, si;
        logic [1:0] z, zp;
        logic       rv;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] ez, input logic [1:0] ezp,
                             input logic erv, input logic [7:0] erate);
        check({name, ".z"}, 32'(z), 32'(ez));
        check({name, ".zp"}, 32'(zp), 32'(ezp));
        check({name, ".rv"}, 32'(rate_valid), 32'(erv));
        check({name, ".rate"}, 32'(rate), 32'(erate));
    endtask

    task automatic drive(input logic ien, input logic irs, input logic [3:0] ia,
                         input logic [7:0] iw, input logic [7:0] iws,
                         input logic [1:0] ib, input logic [1:0] ibs, input logic [1:0] isi);
        en = ien; restart = irs; a = ia; w = iw; w_sign = iws;
        b = ib; b_sign = ibs; state_init = isi;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Per-neuron delta +4 when all inputs and weights are 1 with positive signs.
    task automatic drive_pos(input logic ien, input logic irs, input logic [1:0] isi);
        drive(ien, irs, 4'hF, 8'hFF, 8'h00, 2'b00, 2'b00, isi);
    endtask

    initial begin
        // Rows start from reset state S=7,7 with cnt=0; every window is cut by a restart.
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 8'h00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0}; // 11,11
        vecs[1]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 8'h00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0}; // 15,15
        vecs[2]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 8'h00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0}; // sat 15
        vecs[3]  = '{1'b0, 1'b1, 4'hF, 8'hFF, 8'hFF, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 1'b0}; // S1=7 S0=8
        vecs[4]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 8'hFF, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0}; // 2,3
        vecs[5]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 8'hFF, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0}; // 0,0
        vecs[6]  = '{1'b1, 1'b0, 4'hF, 8'hFF, 8'hFF, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0}; // 0,0
        vecs[7]  = '{1'b0, 1'b1, 4'hF, 8'hF7, 8'hE4, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11, 1'b0}; // 7,7
        vecs[8]  = '{1'b1, 1'b0, 4'hF, 8'hF7, 8'hE4, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 1'b0}; // S1=4 S0=9
        vecs[9]  = '{1'b1, 1'b0, 4'hF, 8'hF7, 8'hE4, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0}; // 1,11
        vecs[10] = '{1'b1, 1'b0, 4'h0, 8'hF7, 8'hE4, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0}; // 1,11
        vecs[11] = '{1'b1, 1'b0, 4'hE, 8'hF7, 8'hE4, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0}; // 0,11
        vecs[12] = '{1'b0, 1'b0, 4'hF, 8'hF7, 8'hE4, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0}; // frozen

        INIT_N = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00);
        #12;
        check_all("in_reset", 2'b00, 2'b11, 1'b0, 8'h00);
        INIT_N = 1'b1;
        drive_pos(1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_all($sformatf("hold_en0_%0d", k), 2'b00, 2'b11, 1'b0, 8'h00);
        end

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].rs, vecs[i].a, vecs[i].w, vecs[i].ws,
                  vecs[i].b, vecs[i].bs, vecs[i].si);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].z, vecs[i].zp, vecs[i].rv, 8'h00);
        end

        // Full window from HALF: z=1 before every edge, so rate=8 per neuron.
        drive_pos(1'b0, 1'b1, 2'b11);
        tick();
        check_all("win_restart", 2'b11, 2'b11, 1'b0, 8'h00);
        drive_pos(1'b1, 1'b0, 2'b11);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 8)      check_all($sformatf("win_e%0d", k), 2'b11, 2'b00, 1'b0, 8'h00);
            else if (k == 8) check_all("win_close", 2'b11, 2'b00, 1'b1, 8'h88);
            else            check_all("win_after", 2'b11, 2'b00, 1'b0, 8'h88);
        end

        // Restart on the window-closing edge suppresses the pulse and holds rate.
        drive_pos(1'b0, 1'b1, 2'b10);
        tick();
        drive_pos(1'b1, 1'b0, 2'b10);
        for (int k = 0; k < 7; k++) tick();
        drive_pos(1'b1, 1'b1, 2'b01);
        tick();
        check_all("rs_close", 2'b01, 2'b11, 1'b0, 8'h88);
        drive_pos(1'b1, 1'b0, 2'b01);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("rs_cnt_e7.rv", 32'(rate_valid), 32'd0);
        end
        check_all("rs_cnt_e8", 2'b11, 2'b00, 1'b1, 8'h78);

        // en toggled 1,1,0,0,1..1: window closes on the 10th clock, S counts +1 per enabled edge.
        drive(1'b0, 1'b1, 4'h1, 8'h11, 8'h00, 2'b00, 2'b00, 2'b00);
        tick();
        check_all("tog_restart", 2'b00, 2'b11, 1'b0, 8'h78);
        for (int k = 1; k <= 10; k++) begin
            logic [1:0] ezp;
            en = !(k == 3 || k == 4);
            restart = 1'b0;
            tick();
            ezp = (k <= 4) ? 2'b11 : 2'b00;  // S 8,9,9,9 inside band, then 10..15
            check_all($sformatf("tog_c%0d", k), 2'b11, ezp, (k == 10), (k == 10) ? 8'h77 : 8'h78);
        end

        // Asynchronous reset mid-window takes effect without a clock edge.
        drive_pos(1'b1, 1'b0, 2'b00);
        tick();
        tick();
        #2;
        INIT_N = 1'b0;
        #1;
        check_all("async_rst", 2'b00, 2'b11, 1'b0, 8'h00);
        en = 1'b0;
        #2;
        INIT_N = 1'b1;
        drive_pos(1'b1, 1'b0, 2'b00);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("post_rst_e7.rv", 32'(rate_valid), 32'd0);
        end
        check_all("post_rst_e8", 2'b11, 2'b00, 1'b1, 8'h77);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
